// File: rtl/ctpuf_resp_gen.sv
// CTPUF response generator: majority-voted multi-bit response from the tristate PUF cell.
// Optional macro PUF_UNSTABLE_EN adds a per-bit non-unanimous vote flag output.
module ctpuf_resp_gen #(
  parameter int CHAL_W = 8,
  parameter int RESP_W = 8,
  parameter int N_EVAL = 5,
  parameter int SETTLE = 4
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   start,
  input  logic [CHAL_W-1:0]                                      chal,
  output logic                                                   busy,
  output logic                                                   puf_en,
  output logic [CHAL_W+((RESP_W > 1) ? $clog2(RESP_W) : 1)-1:0] puf_chal,
  input  logic                                                   puf_bit,
  output logic [RESP_W-1:0]                                      resp,
  output logic                                                   resp_valid,
`ifdef PUF_UNSTABLE_EN
  output logic [RESP_W-1:0]                                      unstable,
`endif
  input  logic                                                   resp_ack
);

  localparam int IDX_W  = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int CNT_W  = $clog2(N_EVAL + 1);
  localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GAP    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state;
  logic [CHAL_W-1:0] chal_q;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  eval_cnt;
  logic [CNT_W-1:0]  ones;
  logic [CNT_W-1:0]  ones_nxt;
  logic [SCNT_W-1:0] settle_cnt;
  logic [RESP_W-1:0] resp_q;
  logic              vote;
`ifdef PUF_UNSTABLE_EN
  logic [RESP_W-1:0] unst_q;
  logic              split;
`endif

  // Vote includes the sample being taken this cycle.
  always_comb begin
    ones_nxt = ones + CNT_W'(puf_bit);
    vote     = (ones_nxt >= CNT_W'((N_EVAL + 1) / 2));
  end

`ifdef PUF_UNSTABLE_EN
  always_comb begin
    split = (ones_nxt != '0) && (ones_nxt != CNT_W'(N_EVAL));
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      chal_q     <= '0;
      idx        <= '0;
      eval_cnt   <= '0;
      ones       <= '0;
      settle_cnt <= '0;
      resp_q     <= '0;
`ifdef PUF_UNSTABLE_EN
      unst_q     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            chal_q   <= chal;
            idx      <= '0;
            eval_cnt <= '0;
            ones     <= '0;
            resp_q   <= '0;
`ifdef PUF_UNSTABLE_EN
            unst_q   <= '0;
`endif
            state    <= S_GAP;
          end
        end
        S_GAP: begin
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SCNT_W'(SETTLE - 1)) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          if (eval_cnt != CNT_W'(N_EVAL - 1)) begin
            eval_cnt <= eval_cnt + 1'b1;
            ones     <= ones_nxt;
            state    <= S_GAP;
          end else begin
            // Decoded write avoids a variable bit-select on a possibly 1-bit vector.
            for (int unsigned i = 0; i < RESP_W; i++) begin
              if (idx == IDX_W'(i)) begin
                resp_q[i] <= vote;
`ifdef PUF_UNSTABLE_EN
                unst_q[i] <= split;
`endif
              end
            end
            eval_cnt <= '0;
            ones     <= '0;
            if (idx == IDX_W'(RESP_W - 1)) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_GAP;
            end
          end
        end
        S_DONE: begin
          if (resp_ack) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != S_IDLE);
    puf_en     = (state == S_SETTLE) || (state == S_SAMPLE);
    resp_valid = (state == S_DONE);
    puf_chal   = (state == S_IDLE) ? '0 : {chal_q, idx};
    resp       = resp_valid ? resp_q : '0;
`ifdef PUF_UNSTABLE_EN
    unstable   = resp_valid ? unst_q : '0;
`endif
  end

endmodule

// File: tb/tb_ctpuf_resp_gen.sv
// Directed bench for ctpuf_resp_gen: default-parameter instance plus a minimal
// RESP_W=1/N_EVAL=1/SETTLE=1 instance; behavioural PUF models drive puf_bit.
module tb_ctpuf_resp_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  chal = '0;
  logic        busy, puf_en, puf_bit, resp_valid;
  logic        resp_ack = 1'b0;
  logic [10:0] puf_chal;
  logic [7:0]  resp;
`ifdef PUF_UNSTABLE_EN
  logic [7:0]  unstable;
`endif

  logic        start_s = 1'b0;
  logic        busy_s, puf_en_s, resp_valid_s;
  logic        resp_ack_s = 1'b0;
  logic [8:0]  puf_chal_s;
  logic [0:0]  resp_s;
`ifdef PUF_UNSTABLE_EN
  logic [0:0]  unstable_s;
`endif

  int          errors = 0;
  int          checks = 0;
  int          mode = 0;
  int          s = 0;
  logic        prev_en = 1'b0;
  logic [39:0] noisy;
  logic        noisy_bit;

  always #5 clk = ~clk;

  ctpuf_resp_gen #(.CHAL_W(8), .RESP_W(8), .N_EVAL(5), .SETTLE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .chal(chal), .busy(busy),
    .puf_en(puf_en), .puf_chal(puf_chal), .puf_bit(puf_bit), .resp(resp),
    .resp_valid(resp_valid),
`ifdef PUF_UNSTABLE_EN
    .unstable(unstable),
`endif
    .resp_ack(resp_ack)
  );

  ctpuf_resp_gen #(.CHAL_W(8), .RESP_W(1), .N_EVAL(1), .SETTLE(1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .chal(chal), .busy(busy_s),
    .puf_en(puf_en_s), .puf_chal(puf_chal_s), .puf_bit(1'b1), .resp(resp_s),
    .resp_valid(resp_valid_s),
`ifdef PUF_UNSTABLE_EN
    .unstable(unstable_s),
`endif
    .resp_ack(resp_ack_s)
  );

  // Noisy model: sample sequence number s counts completed evaluations of the run.
  // Bit 0 votes 1,1,0,1,0 (s=0..4), bit 1 votes 0,1,0,0,1 (s=5..9), rest 0.
  initial noisy = {30'b0, 5'b10010, 5'b01011};
  always @(negedge clk) begin
    if (!busy) s = 0;
    else if (prev_en && !puf_en) s = s + 1;
    prev_en = puf_en;
  end
  assign noisy_bit = (s < 40) ? noisy[s[5:0]] : 1'b0;
  assign puf_bit = (mode == 0) ? ^puf_chal : (mode == 1) ? noisy_bit : (mode == 2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input string nm, input logic [7:0] c, input logic [7:0] er,
                         input logic [7:0] eu, input bit disturb, input int hold);
    int n, en_hi, en_lo, busy_bad, chal_bad;
    n = 0; en_hi = 0; en_lo = 0; busy_bad = 0; chal_bad = 0;
    chal = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!resp_valid && n < 1000) begin
      if (!busy) busy_bad++;
      if (puf_en) begin
        en_hi++;
        if (puf_chal[10:3] !== c) chal_bad++;
      end else en_lo++;
      if (disturb) begin
        start    = (n == 50 || n == 120);
        resp_ack = (n == 70);
        if (n == 50) chal = c ^ 8'h01;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; resp_ack = 1'b0;
    chk({nm, " latency"}, n, 240);
    chk({nm, " resp"}, resp, er);
`ifdef PUF_UNSTABLE_EN
    chk({nm, " unstable"}, unstable, eu);
`else
    if (eu != 8'h00) chk({nm, " eu unused"}, 0, 0);
`endif
    chk({nm, " puf_en high cycles"}, en_hi, 200);
    chk({nm, " gap cycles"}, en_lo, 40);
    chk({nm, " busy drop"}, busy_bad, 0);
    chk({nm, " puf_chal upper"}, chal_bad, 0);
    repeat (hold) begin @(posedge clk); #1; end
    chk({nm, " valid held"}, resp_valid, 1);
    chk({nm, " resp held"}, resp, er);
    resp_ack = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    resp_ack = 1'b0; start = 1'b0;
    chk({nm, " valid after ack"}, resp_valid, 0);
    chk({nm, " idle after ack"}, busy, 0);
    chk({nm, " resp gated"}, resp, 0);
    @(posedge clk); #1;
    chk({nm, " no restart"}, busy, 0);
  endtask

  typedef struct {
    string      nm;
    int         mode;
    logic [7:0] chal;
    logic [7:0] resp;
    logic [7:0] unst;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n, bad;
    vecs[0] = '{"par_a5", 0, 8'hA5, 8'h96, 8'h00};
    vecs[1] = '{"par_00", 0, 8'h00, 8'h96, 8'h00};
    vecs[2] = '{"par_01", 0, 8'h01, 8'h69, 8'h00};
    vecs[3] = '{"par_07", 0, 8'h07, 8'h69, 8'h00};
    vecs[4] = '{"noisy",  1, 8'h3C, 8'h01, 8'h03};
    vecs[5] = '{"ones",   2, 8'h5A, 8'hFF, 8'h00};
    vecs[6] = '{"zeros",  3, 8'hC3, 8'h00, 8'h00};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      resp_ack = i[0];
      @(posedge clk); #1;
      if (busy || puf_en || puf_chal != '0 || resp != '0 || resp_valid) bad++;
    end
    resp_ack = 1'b0;
    chk("reset idle outputs", bad, 0);
    chk("reset busy", busy, 0);
    chk("reset puf_chal", puf_chal, 0);

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      run_txn(vecs[i].nm, vecs[i].chal, vecs[i].resp, vecs[i].unst, 1'b0, 0);
    end

    mode = 0;
    run_txn("disturb", 8'hA5, 8'h96, 8'h00, 1'b1, 50);

    // Reset mid-run: abort, no valid, then a clean run still works.
    chal = 8'hA5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset busy", busy, 0);
    chk("midreset puf_en", puf_en, 0);
    chk("midreset valid", resp_valid, 0);
    bad = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (resp_valid || busy) bad++;
    end
    chk("midreset stays idle", bad, 0);
    run_txn("after_reset", 8'hA5, 8'h96, 8'h00, 1'b0, 0);

    // Minimal configuration: GAP, SETTLE, SAMPLE -> DONE.
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    n = 0;
    while (!resp_valid_s && n < 20) begin @(posedge clk); #1; n++; end
    chk("small latency", n, 3);
    chk("small resp", resp_s, 1);
    resp_ack_s = 1'b1;
    @(posedge clk); #1;
    resp_ack_s = 1'b0;
    chk("small idle", busy_s, 0);
    chk("small resp gated", resp_s, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
